// File: rtl/svm_multiclass_engine.sv
// One-vs-rest SVM scorer: per class, a lane-parallel feature x support-vector dot stage
// followed by a serial alpha-weighted sum, then intercept, sign decision and running argmax.
module svm_multiclass_engine #(
  parameter int NBITS     = 9,
  parameter int NCLASS    = 4,
  parameter int F_WIDTH   = 214,
  parameter int SUP_WIDTH = 155,
  parameter int NPARALLEL = 31,
  localparam int NB  = SUP_WIDTH / NPARALLEL,
  localparam int A1W = 2 * NBITS + $clog2(F_WIDTH),
  localparam int SW  = A1W + NBITS + $clog2(SUP_WIDTH),
  localparam int CAW = $clog2(NCLASS * NB * F_WIDTH),
  localparam int AAW = $clog2(NCLASS * SUP_WIDTH),
  localparam int CW  = $clog2(NCLASS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NBITS*F_WIDTH-1:0]     in_features,
  input  logic                         fin_valid,
  output logic                         fin_ready,
  output logic                         coef_rd_en,
  output logic [CAW-1:0]               coef_rd_addr,
  input  logic [NPARALLEL*NBITS-1:0]   coef_rd_data,
  output logic                         alpha_rd_en,
  output logic [AAW-1:0]               alpha_rd_addr,
  input  logic [NBITS-1:0]             alpha_rd_data,
  input  logic                         icpt_we,
  input  logic [CW-1:0]                icpt_class,
  input  logic [SW-1:0]                icpt_data,
  output logic [NCLASS-1:0]            dout_bits,
  output logic [CW-1:0]                dout_argmax,
  output logic [SW-1:0]                dout_max_score,
  output logic                         dout_valid,
  input  logic                         dout_ready
);

  localparam int KMAX = (F_WIDTH > SUP_WIDTH) ? F_WIDTH : SUP_WIDTH;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int FIW  = $clog2(F_WIDTH);
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {IDLE, MAT1, MAT2, DECIDE, OUT} state_t;

  state_t state, next_state;

  logic [KW-1:0]                cnt;
  logic [BW-1:0]                blk;
  logic [CW-1:0]                cls;
  logic [FIW-1:0]               fidx;
  logic signed [NBITS-1:0]      feat_arr [F_WIDTH];
  logic signed [A1W-1:0]        acc      [NPARALLEL];
  logic signed [A1W-1:0]        lane_prod[NPARALLEL];
  logic signed [A1W-1:0]        dot      [SUP_WIDTH];
  logic signed [SW-1:0]         icpt     [NCLASS];
  logic signed [SW-1:0]         score, max_score, sv_prod, total;
  logic [NCLASS-1:0]            bits;
  logic [CW-1:0]                argmax;
  logic                         last_f, last_s, last_blk, last_cls;

  assign last_f   = (cnt == KW'(F_WIDTH));
  assign last_s   = (cnt == KW'(SUP_WIDTH));
  assign last_blk = (blk == BW'(NB - 1));
  assign last_cls = (cls == CW'(NCLASS - 1));
  // Data arriving this cycle belongs to the request issued one cycle earlier.
  assign fidx     = FIW'(cnt - 1'b1);

  assign fin_ready      = (state == IDLE);
  assign dout_valid     = (state == OUT);
  assign coef_rd_en     = (state == MAT1) && !last_f;
  assign alpha_rd_en    = (state == MAT2) && !last_s;
  assign coef_rd_addr   = CAW'((int'(cls) * NB + int'(blk)) * F_WIDTH + int'(cnt));
  assign alpha_rd_addr  = AAW'(int'(cls) * SUP_WIDTH + int'(cnt));
  assign dout_bits      = bits;
  assign dout_argmax    = argmax;
  assign dout_max_score = max_score;

  always_comb begin
    for (int p = 0; p < NPARALLEL; p++) begin
      lane_prod[p] = A1W'(signed'(coef_rd_data[p*NBITS +: NBITS])) * A1W'(feat_arr[fidx]);
    end
    sv_prod = SW'(dot[0]) * SW'(signed'(alpha_rd_data));
    total   = score + icpt[cls];
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fin_valid) next_state = MAT1;
      MAT1:    if (last_f && last_blk) next_state = MAT2;
      MAT2:    if (last_s) next_state = DECIDE;
      DECIDE:  next_state = last_cls ? OUT : MAT1;
      OUT:     if (dout_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      blk       <= '0;
      cls       <= '0;
      score     <= '0;
      max_score <= '0;
      argmax    <= '0;
      bits      <= '0;
      for (int f = 0; f < F_WIDTH; f++)   feat_arr[f] <= '0;
      for (int p = 0; p < NPARALLEL; p++) acc[p]      <= '0;
      for (int s = 0; s < SUP_WIDTH; s++) dot[s]      <= '0;
      for (int c = 0; c < NCLASS; c++)    icpt[c]     <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (icpt_we && ({1'b0, icpt_class} < (CW+1)'(NCLASS)))
            icpt[icpt_class] <= icpt_data;
          if (fin_valid) begin
            for (int f = 0; f < F_WIDTH; f++) feat_arr[f] <= in_features[f*NBITS +: NBITS];
            cnt <= '0;
            blk <= '0;
            cls <= '0;
          end
        end
        MAT1: begin
          if (last_f) begin
            // Block results shift in from the top so block b lands at dot[b*NPARALLEL +: NPARALLEL].
            for (int s = 0; s < SUP_WIDTH - NPARALLEL; s++) dot[s] <= dot[s+NPARALLEL];
            for (int p = 0; p < NPARALLEL; p++) begin
              dot[SUP_WIDTH-NPARALLEL+p] <= acc[p] + lane_prod[p];
              acc[p] <= '0;
            end
            cnt <= '0;
            if (last_blk) begin
              blk   <= '0;
              score <= '0;
            end else begin
              blk <= blk + 1'b1;
            end
          end else begin
            if (cnt != '0)
              for (int p = 0; p < NPARALLEL; p++) acc[p] <= acc[p] + lane_prod[p];
            cnt <= cnt + 1'b1;
          end
        end
        MAT2: begin
          if (cnt != '0) begin
            score <= score + sv_prod;
            for (int s = 0; s < SUP_WIDTH - 1; s++) dot[s] <= dot[s+1];
            dot[SUP_WIDTH-1] <= dot[0];
          end
          cnt <= last_s ? '0 : cnt + 1'b1;
        end
        DECIDE: begin
          bits[cls] <= (total > 0);
          if (cls == '0 || total > max_score) begin
            max_score <= total;
            argmax    <= cls;
          end
          if (!last_cls) cls <= cls + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_multiclass_engine.sv
// Bench for svm_multiclass_engine: a small configuration checked against a plain-arithmetic
// SVM model with random data, plus a default-size instance for the max-negative operand case.
module tb_svm_multiclass_engine;

  localparam int NBITS = 9, NCL = 2, FW = 4, SUPW = 4, NP = 2, NB = 2, SW = 31;
  localparam int LAT = NCL * (NB * (FW + 1) + SUPW + 2) + 1;
  localparam int BF = 214, BSUP = 155, BNP = 31, BNCL = 4, SWB = 43;
  localparam int LATB = BNCL * ((BSUP / BNP) * (BF + 1) + BSUP + 2) + 1;

  logic clk, rst;
  logic [NBITS*FW-1:0] in_features;
  logic fin_valid, fin_ready, coef_rd_en, alpha_rd_en, icpt_we, dout_valid, dout_ready;
  logic [3:0] coef_rd_addr;
  logic [NP*NBITS-1:0] coef_rd_data;
  logic [2:0] alpha_rd_addr;
  logic [NBITS-1:0] alpha_rd_data;
  logic [0:0] icpt_class, dout_argmax;
  logic [SW-1:0] icpt_data, dout_max_score;
  logic [1:0] dout_bits;

  logic [NBITS*BF-1:0] in_features_b;
  logic fin_valid_b, fin_ready_b, coef_rd_en_b, alpha_rd_en_b, icpt_we_b, dout_valid_b, dout_ready_b;
  logic [12:0] coef_rd_addr_b;
  logic [BNP*NBITS-1:0] coef_rd_data_b;
  logic [9:0] alpha_rd_addr_b;
  logic [NBITS-1:0] alpha_rd_data_b;
  logic [1:0] icpt_class_b, dout_argmax_b;
  logic [SWB-1:0] icpt_data_b, dout_max_score_b;
  logic [3:0] dout_bits_b;

  int coef_m [NCL][SUPW][FW];
  int alpha_m[NCL][SUPW];
  int feat_m [FW];
  longint icpt_m[NCL];
  int checks = 0, passes = 0;

  svm_multiclass_engine #(.NBITS(NBITS), .NCLASS(NCL), .F_WIDTH(FW), .SUP_WIDTH(SUPW), .NPARALLEL(NP)) dut (
    .clk(clk), .rst(rst), .in_features(in_features), .fin_valid(fin_valid), .fin_ready(fin_ready),
    .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
    .alpha_rd_en(alpha_rd_en), .alpha_rd_addr(alpha_rd_addr), .alpha_rd_data(alpha_rd_data),
    .icpt_we(icpt_we), .icpt_class(icpt_class), .icpt_data(icpt_data),
    .dout_bits(dout_bits), .dout_argmax(dout_argmax), .dout_max_score(dout_max_score),
    .dout_valid(dout_valid), .dout_ready(dout_ready));

  svm_multiclass_engine dut_big (
    .clk(clk), .rst(rst), .in_features(in_features_b), .fin_valid(fin_valid_b), .fin_ready(fin_ready_b),
    .coef_rd_en(coef_rd_en_b), .coef_rd_addr(coef_rd_addr_b), .coef_rd_data(coef_rd_data_b),
    .alpha_rd_en(alpha_rd_en_b), .alpha_rd_addr(alpha_rd_addr_b), .alpha_rd_data(alpha_rd_data_b),
    .icpt_we(icpt_we_b), .icpt_class(icpt_class_b), .icpt_data(icpt_data_b),
    .dout_bits(dout_bits_b), .dout_argmax(dout_argmax_b), .dout_max_score(dout_max_score_b),
    .dout_valid(dout_valid_b), .dout_ready(dout_ready_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NP*NBITS-1:0] coef_word(input int addr);
    int cb, f, c, b;
    logic [NP*NBITS-1:0] w;
    cb = addr / FW; f = addr % FW; c = cb / NB; b = cb % NB; w = '0;
    if (c < NCL)
      for (int p = 0; p < NP; p++) w[p*NBITS +: NBITS] = NBITS'(coef_m[c][b*NP+p][f]);
    return w;
  endfunction

  function automatic logic [NBITS-1:0] alpha_word(input int addr);
    if (addr / SUPW < NCL) return NBITS'(alpha_m[addr / SUPW][addr % SUPW]);
    return '0;
  endfunction

  always @(posedge clk) begin
    if (coef_rd_en)    coef_rd_data    <= coef_word(int'(coef_rd_addr));
    if (alpha_rd_en)   alpha_rd_data   <= alpha_word(int'(alpha_rd_addr));
    if (coef_rd_en_b)  coef_rd_data_b  <= {BNP{9'h100}};
    if (alpha_rd_en_b) alpha_rd_data_b <= 9'h100;
  end

  function automatic int rv();
    case ($urandom_range(0, 7))
      0:       return -256;
      1:       return 255;
      default: return int'($urandom_range(0, 511)) - 256;
    endcase
  endfunction

  task automatic fill_random();
    for (int c = 0; c < NCL; c++)
      for (int s = 0; s < SUPW; s++) begin
        alpha_m[c][s] = rv();
        for (int f = 0; f < FW; f++) coef_m[c][s][f] = rv();
      end
    for (int f = 0; f < FW; f++) feat_m[f] = rv();
  endtask

  task automatic fill_const(input int v);
    for (int c = 0; c < NCL; c++)
      for (int s = 0; s < SUPW; s++) begin
        alpha_m[c][s] = v;
        for (int f = 0; f < FW; f++) coef_m[c][s][f] = v;
      end
    for (int f = 0; f < FW; f++) feat_m[f] = v;
  endtask

  task automatic apply_features();
    for (int f = 0; f < FW; f++) in_features[f*NBITS +: NBITS] = NBITS'(feat_m[f]);
  endtask

  // score_c = intercept_c + sum_s alpha_cs * (sum_f coef_csf * x_f); strict > keeps the lower index on ties
  task automatic model(output logic [1:0] eb, output int ea, output longint es);
    longint tot, d;
    eb = '0; ea = 0; es = 0;
    for (int c = 0; c < NCL; c++) begin
      tot = icpt_m[c];
      for (int s = 0; s < SUPW; s++) begin
        d = 0;
        for (int f = 0; f < FW; f++) d += longint'(coef_m[c][s][f]) * feat_m[f];
        tot += d * alpha_m[c][s];
      end
      eb[c] = (tot > 0);
      if (c == 0 || tot > es) begin es = tot; ea = c; end
    end
  endtask

  task automatic load_icpt(input int c, input longint v);
    icpt_we = 1'b1; icpt_class = 1'(c); icpt_data = SW'(v);
    @(negedge clk);
    icpt_we = 1'b0;
    icpt_m[c] = v;
  endtask

  task automatic wait_out(output int cyc, output int nc, output int na);
    fin_valid = 1'b1; cyc = 0; nc = 0; na = 0;
    do begin
      @(negedge clk);
      cyc++; fin_valid = 1'b0;
      nc += int'(coef_rd_en); na += int'(alpha_rd_en);
    end while (!dout_valid && cyc < 200);
  endtask

  task automatic release_out();
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (fin_ready !== 1'b1) $display("FAIL reset_fin_ready got %b want 1", fin_ready); else passes++;
    checks++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid got %b want 0", dout_valid); else passes++;
    checks++; if ({dout_bits, dout_argmax} !== 3'b000) $display("FAIL reset_bits_argmax got %b want 000", {dout_bits, dout_argmax}); else passes++;
    checks++; if (dout_max_score !== '0) $display("FAIL reset_max_score got %0d want 0", dout_max_score); else passes++;
    checks++; if ({coef_rd_en, alpha_rd_en} !== 2'b00) $display("FAIL reset_rd_en got %b want 00", {coef_rd_en, alpha_rd_en}); else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones();
    int cyc, nc, na;
    fill_const(1); apply_features();
    checks++; if (fin_ready !== 1'b1) $display("FAIL ones_fin_ready got %b want 1", fin_ready); else passes++;
    wait_out(cyc, nc, na);
    checks++; if (cyc !== LAT) $display("FAIL ones_latency got %0d want %0d", cyc, LAT); else passes++;
    checks++; if (nc !== NCL * NB * FW) $display("FAIL ones_coef_reads got %0d want %0d", nc, NCL * NB * FW); else passes++;
    checks++; if (na !== NCL * SUPW) $display("FAIL ones_alpha_reads got %0d want %0d", na, NCL * SUPW); else passes++;
    checks++; if (dout_bits !== 2'b11) $display("FAIL ones_bits got %b want 11", dout_bits); else passes++;
    checks++; if (dout_argmax !== 1'b0) $display("FAIL ones_argmax got %0d want 0", dout_argmax); else passes++;
    checks++; if ($signed(dout_max_score) !== 31'sd16) $display("FAIL ones_score got %0d want 16", $signed(dout_max_score)); else passes++;
    release_out();
    checks++; if ({fin_ready, dout_valid} !== 2'b10) $display("FAIL ones_release got %b want 10", {fin_ready, dout_valid}); else passes++;
  endtask

  task automatic test_intercepts();
    int cyc, nc, na;
    load_icpt(0, -20); load_icpt(1, -10);
    fill_const(1); apply_features();
    wait_out(cyc, nc, na);
    checks++; if (dout_bits !== 2'b10) $display("FAIL icpt_bits got %b want 10", dout_bits); else passes++;
    checks++; if (dout_argmax !== 1'b1) $display("FAIL icpt_argmax got %0d want 1", dout_argmax); else passes++;
    checks++; if ($signed(dout_max_score) !== 31'sd6) $display("FAIL icpt_score got %0d want 6", $signed(dout_max_score)); else passes++;
    release_out();
  endtask

  task automatic test_random();
    int cyc, nc, na, ea;
    logic [1:0] eb;
    longint es;
    for (int it = 0; it < 20; it++) begin
      for (int c = 0; c < NCL; c++) load_icpt(c, longint'($urandom_range(0, 1 << 22)) - (1 << 21));
      fill_random(); apply_features(); model(eb, ea, es);
      wait_out(cyc, nc, na);
      checks++; if (cyc !== LAT) $display("FAIL rand_latency it=%0d got %0d want %0d", it, cyc, LAT); else passes++;
      checks++; if (nc !== NCL * NB * FW || na !== NCL * SUPW) $display("FAIL rand_reads it=%0d got %0d/%0d want %0d/%0d", it, nc, na, NCL * NB * FW, NCL * SUPW); else passes++;
      checks++; if (dout_bits !== eb) $display("FAIL rand_bits it=%0d got %b want %b", it, dout_bits, eb); else passes++;
      checks++; if (int'(dout_argmax) !== ea) $display("FAIL rand_argmax it=%0d got %0d want %0d", it, dout_argmax, ea); else passes++;
      checks++; if (longint'($signed(dout_max_score)) !== es) $display("FAIL rand_score it=%0d got %0d want %0d", it, $signed(dout_max_score), es); else passes++;
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int cyc, nc, na, ea, ea2, errs;
    logic [1:0] eb, eb2;
    longint es, es2;
    fill_random(); apply_features(); model(eb, ea, es);
    wait_out(cyc, nc, na);
    checks++; if (longint'($signed(dout_max_score)) !== es) $display("FAIL bp_first_score got %0d want %0d", $signed(dout_max_score), es); else passes++;
    fill_random(); apply_features(); model(eb2, ea2, es2);
    fin_valid = 1'b1; errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (dout_valid !== 1'b1 || fin_ready !== 1'b0 || dout_bits !== eb || int'(dout_argmax) !== ea ||
          longint'($signed(dout_max_score)) !== es) errs++;
    end
    checks++; if (errs !== 0) $display("FAIL bp_hold_stable got %0d bad cycles want 0", errs); else passes++;
    release_out();
    checks++; if ({fin_ready, dout_valid} !== 2'b10) $display("FAIL bp_release got %b want 10", {fin_ready, dout_valid}); else passes++;
    wait_out(cyc, nc, na);
    checks++; if (cyc !== LAT) $display("FAIL bp_next_latency got %0d want %0d", cyc, LAT); else passes++;
    checks++; if (dout_bits !== eb2 || int'(dout_argmax) !== ea2) $display("FAIL bp_next_decision got %b/%0d want %b/%0d", dout_bits, dout_argmax, eb2, ea2); else passes++;
    checks++; if (longint'($signed(dout_max_score)) !== es2) $display("FAIL bp_next_score got %0d want %0d", $signed(dout_max_score), es2); else passes++;
    release_out();
  endtask

  task automatic test_icpt_ignore();
    int cyc, ea;
    logic [1:0] eb;
    longint es;
    load_icpt(0, 500); load_icpt(1, -300);
    fill_random(); apply_features(); model(eb, ea, es);
    fin_valid = 1'b1;
    @(negedge clk);
    fin_valid = 1'b0;
    icpt_we = 1'b1; icpt_class = 1'b0; icpt_data = SW'(-(longint'(1) << 28));
    @(negedge clk);
    icpt_we = 1'b0; cyc = 2;
    while (!dout_valid && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== LAT) $display("FAIL ign_latency got %0d want %0d", cyc, LAT); else passes++;
    checks++; if (dout_bits !== eb || int'(dout_argmax) !== ea) $display("FAIL ign_decision got %b/%0d want %b/%0d", dout_bits, dout_argmax, eb, ea); else passes++;
    checks++; if (longint'($signed(dout_max_score)) !== es) $display("FAIL ign_score got %0d want %0d", $signed(dout_max_score), es); else passes++;
    release_out();
  endtask

  task automatic test_reset_mid();
    int cyc, nc, na, ea;
    logic [1:0] eb;
    longint es;
    load_icpt(0, 1000); load_icpt(1, -777);
    fill_random(); apply_features();
    fin_valid = 1'b1; cyc = 0;
    do begin @(negedge clk); cyc++; fin_valid = 1'b0; end while (cyc < 12);
    checks++; if (alpha_rd_en !== 1'b1) $display("FAIL mid_in_mat2 got %b want 1", alpha_rd_en); else passes++;
    rst = 1'b1;
    #1;
    checks++; if ({fin_ready, dout_valid, coef_rd_en, alpha_rd_en} !== 4'b1000) $display("FAIL mid_rst_ctrl got %b want 1000", {fin_ready, dout_valid, coef_rd_en, alpha_rd_en}); else passes++;
    checks++; if ({dout_bits, dout_argmax} !== 3'b000 || dout_max_score !== '0) $display("FAIL mid_rst_outputs got %b/%0d want 000/0", {dout_bits, dout_argmax}, dout_max_score); else passes++;
    @(negedge clk);
    rst = 1'b0;
    icpt_m[0] = 0; icpt_m[1] = 0;
    @(negedge clk);
    fill_random(); apply_features(); model(eb, ea, es);
    wait_out(cyc, nc, na);
    checks++; if (cyc !== LAT) $display("FAIL mid_post_latency got %0d want %0d", cyc, LAT); else passes++;
    checks++; if (longint'($signed(dout_max_score)) !== es || dout_bits !== eb) $display("FAIL mid_post_result got %0d/%b want %0d/%b", $signed(dout_max_score), dout_bits, es, eb); else passes++;
    release_out();
  endtask

  task automatic test_max_negative();
    int cyc;
    longint es;
    es = longint'(BF) * 256 * 256 * (-256) * BSUP;
    fin_valid_b = 1'b1; cyc = 0;
    do begin @(negedge clk); cyc++; fin_valid_b = 1'b0; end while (!dout_valid_b && cyc < 6000);
    checks++; if (cyc !== LATB) $display("FAIL maxneg_latency got %0d want %0d", cyc, LATB); else passes++;
    checks++; if (longint'($signed(dout_max_score_b)) !== es) $display("FAIL maxneg_score got %0d want %0d", $signed(dout_max_score_b), es); else passes++;
    checks++; if ({dout_bits_b, dout_argmax_b} !== 6'b0) $display("FAIL maxneg_bits_argmax got %b want 000000", {dout_bits_b, dout_argmax_b}); else passes++;
    dout_ready_b = 1'b1;
    @(negedge clk);
    dout_ready_b = 1'b0;
    checks++; if (fin_ready_b !== 1'b1) $display("FAIL maxneg_release got %b want 1", fin_ready_b); else passes++;
  endtask

  initial begin
    rst = 1'b1; fin_valid = 1'b0; dout_ready = 1'b0; icpt_we = 1'b0; icpt_class = '0; icpt_data = '0;
    in_features = '0; fin_valid_b = 1'b0; dout_ready_b = 1'b0; icpt_we_b = 1'b0;
    icpt_class_b = '0; icpt_data_b = '0; in_features_b = {BF{9'h100}};
    icpt_m[0] = 0; icpt_m[1] = 0;
    test_reset();
    test_ones();
    test_intercepts();
    test_random();
    test_backpressure();
    test_icpt_ignore();
    test_reset_mid();
    test_max_negative();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
